// File: rtl/simple_lsu.sv
// ----------------------------------------------------------------------------
// simple_lsu
//
// Load/store unit between the execute stage and simple_memory. It accepts one
// load or store per request handshake and latches it. In the following cycle it
// checks alignment, size and range. It then either strobes the memory write
// port or captures the zero/sign-extended read data. The result is returned
// through a registered valid/ready response.
//
// Sequence:  IDLE --accept--> ACCESS --(always)--> RESP --resp handshake--> IDLE
//
// Ports
//   iwClk, iwRst        clock, synchronous active-high reset
//   iwReqValid/owReqReady
//                       request handshake (ready only in IDLE)
//   iwReqWrite          1 = store, 0 = load
//   iwReqAddr           byte address
//   iwReqSize           0 byte, 1 half, 2 word, 3 illegal
//   iwReqSigned         sign-extend loads
//   iwReqWData          right-aligned store data
//   owRespValid/iwRespReady
//                       response handshake
//   owRespData          load result (0 for stores and errors)
//   owRespErr           misaligned, out-of-range or illegal size
//   owMemReadAddr       latched address to the memory read port
//   iwMemReadData       combinational memory read data, addressed byte in [7:0]
//   owMemWriteAddr      latched address to the memory write port
//   owMemWriteData      latched store data, unshifted
//   owMemWstrb          byte write strobes, nonzero only in a good store ACCESS
// ----------------------------------------------------------------------------
module simple_lsu #(
   parameter int unsigned pMemBytes = 32'd512
) (
   input  logic        iwClk,
   input  logic        iwRst,
   // request channel
   input  logic        iwReqValid,
   output logic        owReqReady,
   input  logic        iwReqWrite,
   input  logic [31:0] iwReqAddr,
   input  logic [1:0]  iwReqSize,
   input  logic        iwReqSigned,
   input  logic [31:0] iwReqWData,
   // response channel
   output logic        owRespValid,
   input  logic        iwRespReady,
   output logic [31:0] owRespData,
   output logic        owRespErr,
   // memory side
   output logic [31:0] owMemReadAddr,
   input  logic [31:0] iwMemReadData,
   output logic [31:0] owMemWriteAddr,
   output logic [31:0] owMemWriteData,
   output logic [3:0]  owMemWstrb
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   localparam logic [1:0] SizeByte = 2'd0;
   localparam logic [1:0] SizeHalf = 2'd1;
   localparam logic [1:0] SizeWord = 2'd2;
   localparam logic [1:0] SizeBad  = 2'd3;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_e      state_q, state_d;

   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] wdata_q, wdata_d;

   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_data_q, resp_data_d;

   // -------------------------------------------------------------------------
   // Access checks on the latched request
   // -------------------------------------------------------------------------
   logic        size_err;
   logic        align_err;
   logic        range_err;
   logic        access_err;
   logic [32:0] access_bytes;
   logic [32:0] access_end;
   logic [3:0]  store_strb;
   logic [31:0] load_ext;

   always_comb begin
      size_err     = (size_q == SizeBad);
      align_err    = 1'b0;
      unique case (size_q)
         SizeHalf: align_err = addr_q[0];
         SizeWord: align_err = (addr_q[1:0] != 2'b00);
         default:  align_err = 1'b0;
      endcase
      // 33-bit sum so an address near 2^32 cannot wrap back into range
      access_bytes = 33'd1 << size_q;
      access_end   = {1'b0, addr_q} + access_bytes;
      range_err    = (access_end > {1'b0, pMemBytes});
      access_err   = size_err | align_err | range_err;
   end

   always_comb begin
      store_strb = 4'b0000;
      unique case (size_q)
         SizeByte: store_strb = 4'b0001;
         SizeHalf: store_strb = 4'b0011;
         SizeWord: store_strb = 4'b1111;
         default:  store_strb = 4'b0000;
      endcase
   end

   always_comb begin
      load_ext = iwMemReadData;
      unique case (size_q)
         SizeByte: load_ext = {{24{signed_q & iwMemReadData[7]}}, iwMemReadData[7:0]};
         SizeHalf: load_ext = {{16{signed_q & iwMemReadData[15]}}, iwMemReadData[15:0]};
         default:  load_ext = iwMemReadData;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      addr_d       = addr_q;
      size_d       = size_q;
      signed_d     = signed_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_data_d  = resp_data_q;

      unique case (state_q)
         StIdle: begin
            if (iwReqValid) begin
               write_d  = iwReqWrite;
               addr_d   = iwReqAddr;
               size_d   = iwReqSize;
               signed_d = iwReqSigned;
               wdata_d  = iwReqWData;
               state_d  = StAccess;
            end
         end

         StAccess: begin
            resp_valid_d = 1'b1;
            resp_err_d   = access_err;
            resp_data_d  = (access_err || write_q) ? 32'd0 : load_ext;
            state_d      = StResp;
         end

         StResp: begin
            // Return to IDLE only; the next request is taken a cycle later
            if (iwRespReady) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               state_d      = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge iwClk) begin
      if (iwRst) begin
         state_q      <= StIdle;
         write_q      <= 1'b0;
         addr_q       <= 32'd0;
         size_q       <= 2'd0;
         signed_q     <= 1'b0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      owReqReady     = (state_q == StIdle);
      owRespValid    = resp_valid_q;
      owRespErr      = resp_err_q;
      owRespData     = resp_data_q;
      owMemReadAddr  = addr_q;
      owMemWriteAddr = addr_q;
      owMemWriteData = wdata_q;
      // Strobe gated by reset so a store caught by reset never reaches memory
      owMemWstrb     = 4'b0000;
      if ((state_q == StAccess) && write_q && !access_err && !iwRst) begin
         owMemWstrb = store_strb;
      end
   end

endmodule
